// File: rtl/cnu_block.sv
// Serial min-sum check node unit: collects K V2C messages, then emits K C2V messages and the row syndrome.
// Optional offset min-sum output stage enabled by defining OFFSET_MIN_SUM_EN.
module cnu_block #(
  parameter int K             = 6,
  parameter int MESSAGE_WIDTH = 5,
  parameter int IDX_WIDTH     = 3,
  parameter int OFFSET        = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MESSAGE_WIDTH:0]   vnu_msg,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MESSAGE_WIDTH-1:0] cnu_msg,
  output logic [IDX_WIDTH-1:0]     out_idx,
  output logic                     out_last,
  output logic                     syndrome,
  output logic                     syn_valid
);

  localparam int MAG_W = MESSAGE_WIDTH - 1;
  localparam int CNT_W = $clog2(K + 1);

  // Handshake: a word moves on a rising edge where valid && ready are both high;
  // valid never waits for ready, and the sender holds its data until the transfer.
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;
  state_t state, state_next;

  logic [MAG_W-1:0]     min1, min2, min1_next, min2_next;
  logic [MAG_W-1:0]     base_min1, base_min2;
  logic [IDX_WIDTH-1:0] idx1, idx1_next, base_idx1;
  logic [CNT_W-1:0]     count, pos, count_next;
  logic                 sign_prod, par, base_sp, base_par;
  logic [K-1:0]         sign_reg;

  logic [MAG_W-1:0] in_mag;
  logic             in_sign, in_dec;
  logic             in_fire, out_fire, row_done;
  logic [MAG_W-1:0] sel_mag, out_mag;

  assign in_mag  = vnu_msg[MAG_W-1:0];
  assign in_sign = vnu_msg[MESSAGE_WIDTH-1];
  assign in_dec  = vnu_msg[MESSAGE_WIDTH];

  assign in_ready  = (state != EMIT);
  assign out_valid = (state == EMIT);
  assign out_last  = out_valid && (out_idx == IDX_WIDTH'(K - 1));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // In IDLE the running accumulators restart from a neutral value instead of the old row.
  always_comb begin
    base_min1 = min1;
    base_min2 = min2;
    base_idx1 = idx1;
    base_sp   = sign_prod;
    base_par  = par;
    pos       = count;
    if (state == IDLE) begin
      base_min1 = '1;
      base_min2 = '1;
      base_idx1 = '0;
      base_sp   = 1'b0;
      base_par  = 1'b0;
      pos       = '0;
    end
    min1_next = base_min1;
    min2_next = base_min2;
    idx1_next = base_idx1;
    if (in_mag < base_min1) begin
      min2_next = base_min1;
      min1_next = in_mag;
      idx1_next = IDX_WIDTH'(pos);
    end else if (in_mag < base_min2) begin
      min2_next = in_mag;
    end
    count_next = pos + CNT_W'(1);
  end

  assign row_done = in_fire && (count_next == CNT_W'(K));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_fire) state_next = COLLECT;
      COLLECT: if (row_done) state_next = EMIT;
      EMIT:    if (out_fire && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sel_mag = (out_idx == idx1) ? min2 : min1;

`ifdef OFFSET_MIN_SUM_EN
  localparam logic [MAG_W-1:0] OFF_MAG = MAG_W'(OFFSET);
  assign out_mag = (sel_mag > OFF_MAG) ? (sel_mag - OFF_MAG) : '0;
`else
  assign out_mag = sel_mag;
`endif

  // Extrinsic sign: total product with this position's own sign removed.
  always_comb begin
    cnu_msg = '0;
    if (state == EMIT) cnu_msg = {sign_prod ^ sign_reg[out_idx], out_mag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      min1      <= '0;
      min2      <= '0;
      idx1      <= '0;
      count     <= '0;
      sign_prod <= 1'b0;
      par       <= 1'b0;
      sign_reg  <= '0;
      out_idx   <= '0;
      syndrome  <= 1'b0;
      syn_valid <= 1'b0;
    end else begin
      state     <= state_next;
      syn_valid <= 1'b0;
      if (in_fire) begin
        min1          <= min1_next;
        min2          <= min2_next;
        idx1          <= idx1_next;
        count         <= count_next;
        sign_prod     <= base_sp ^ in_sign;
        par           <= base_par ^ in_dec;
        sign_reg[pos] <= in_sign;
      end
      if (row_done) begin
        syndrome  <= base_par ^ in_dec;
        syn_valid <= 1'b1;
      end
      if (out_fire) out_idx <= out_last ? '0 : out_idx + IDX_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cnu_block.sv
// Directed bench for cnu_block (K=6, MESSAGE_WIDTH=5) with hand-computed rows, backpressure and mid-row reset.
module tb_cnu_block;

  localparam int K  = 6;
  localparam int MW = 5;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [MW:0]   vnu_msg;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] cnu_msg;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          syndrome;
  logic          syn_valid;

  int checks   = 0;
  int failures = 0;

  logic [3:0] row_mag [K];
  logic [3:0] exp_mag [K];
  logic [K-1:0] row_sign, row_dec, exp_sign;
  logic exp_syn;

  cnu_block #(.K(K), .MESSAGE_WIDTH(MW), .IDX_WIDTH(IW), .OFFSET(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .vnu_msg(vnu_msg),
    .out_valid(out_valid), .out_ready(out_ready), .cnu_msg(cnu_msg), .out_idx(out_idx),
    .out_last(out_last), .syndrome(syndrome), .syn_valid(syn_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] adj(input logic [3:0] m);
`ifdef OFFSET_MIN_SUM_EN
    return (m > 4'd1) ? m - 4'd1 : 4'd0;
`else
    return m;
`endif
  endfunction

  // Drive one row; odd positions are preceded by a two-cycle in_valid gap when gaps=1.
  task automatic send_row(input bit gaps);
    for (int i = 0; i < K; i++) begin
      @(negedge clk);
      if (gaps && (i % 2 == 1)) begin
        in_valid = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("gap_out_valid", out_valid, 0);
          check("gap_in_ready", in_ready, 1);
        end
      end
      in_valid = 1'b1;
      vnu_msg  = {row_dec[i], row_sign[i], row_mag[i]};
      @(posedge clk);
    end
  endtask

  // Consume the row's outputs; junk=1 keeps in_valid high during EMIT, stall_at stalls 3 cycles.
  task automatic recv_row(input bit junk, input int stall_at);
    logic [MW-1:0] held;
    @(negedge clk);
    if (junk) begin
      in_valid = 1'b1;
      vnu_msg  = '0;
    end else begin
      in_valid = 1'b0;
    end
    for (int j = 0; j < K; j++) begin
      if (j > 0) @(negedge clk);
      check("out_valid", out_valid, 1);
      check("in_ready_emit", in_ready, 0);
      check("out_idx", out_idx, j);
      check("cnu_msg", cnu_msg, {exp_sign[j], adj(exp_mag[j])});
      check("out_last", out_last, (j == K - 1) ? 1 : 0);
      if (j == 0) begin
        check("syn_valid_pulse", syn_valid, 1);
        check("syndrome", syndrome, exp_syn);
      end
      if (j == 1) check("syn_valid_once", syn_valid, 0);
      if (j == stall_at) begin
        held = cnu_msg;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_cnu_msg", cnu_msg, {exp_sign[j], adj(exp_mag[j])});
          check("stall_held", cnu_msg, held);
          check("stall_out_idx", out_idx, j);
          check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_out_last", out_last, 0);
    check("syndrome_hold", syndrome, exp_syn);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    vnu_msg   = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_cnu_msg", cnu_msg, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_syndrome", syndrome, 0);
    check("rst_syn_valid", syn_valid, 0);
    rst_n = 1'b1;

    // Three poisoned inputs (mag 0, negative, decision 1), then reset mid-row.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      vnu_msg  = 6'b110000;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Row A: distinct mags, min1=3 at 1, min2=5.
    row_mag  = '{4'd7, 4'd3, 4'd9, 4'd5, 4'd12, 4'd6};
    row_sign = 6'b000000;
    row_dec  = 6'b000000;
    exp_mag  = '{4'd3, 4'd5, 4'd3, 4'd3, 4'd3, 4'd3};
    exp_sign = 6'b000000;
    exp_syn  = 1'b0;
    send_row(1'b0);
    recv_row(1'b0, -1);

    // Row B: equal mags, negatives on 1,2,3,5 (even count), in_valid held high during EMIT.
    row_mag  = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
    row_sign = 6'b101110;
    row_dec  = 6'b000000;
    exp_mag  = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
    exp_sign = 6'b101110;
    exp_syn  = 1'b0;
    send_row(1'b0);
    recv_row(1'b1, -1);

    // Row C: tied minima, odd parity, input gaps and output stall at idx 2.
    row_mag  = '{4'd2, 4'd2, 4'd8, 4'd8, 4'd8, 4'd8};
    row_sign = 6'b000000;
    row_dec  = 6'b000001;
    exp_mag  = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    exp_sign = 6'b000000;
    exp_syn  = 1'b1;
    send_row(1'b1);
    recv_row(1'b0, 2);
    repeat (2) @(negedge clk);
    check("syndrome_idle_hold", syndrome, 1);
    check("syn_valid_idle", syn_valid, 0);

    // Row D: negative zero minimum at 0 -> other outputs are negative zero.
    row_mag  = '{4'd0, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
    row_sign = 6'b000001;
    row_dec  = 6'b000011;
    exp_mag  = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    exp_sign = 6'b111110;
    exp_syn  = 1'b0;
    send_row(1'b0);
    recv_row(1'b0, -1);

    // Row E: small minima; offset build saturates to 0.
    row_mag  = '{4'd1, 4'd1, 4'd4, 4'd6, 4'd8, 4'd9};
    row_sign = 6'b000000;
    row_dec  = 6'b000000;
    exp_mag  = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    exp_sign = 6'b000000;
    exp_syn  = 1'b0;
    send_row(1'b0);
    recv_row(1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
